// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter and sequencer for a shared 4:1 datapath mux
//
// Grants one of four requesters at a time, drives the registered mux select,
// and steers the granted requester's data to the output under valid/ready.
// Each grant ends on the requester's last flag, on reaching MAX_BURST beats,
// or when the requester withdraws its request.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   4      request per requester
//   last       in   4      per-requester end-of-packet flag
//   in         in   4*W    packed requester data, requester i at in[i*W +: W]
//   ack        out  4      one-hot beat acknowledge to the granted requester
//   out_valid  out  1      output beat valid
//   out_data   out  W      selected requester data
//   out_last   out  1      final beat of the current grant
//   out_ready  in   1      consumer ready
//   sel        out  2      registered mux select (current or most recent grant)
//   busy       out  1      high while a grant is active

module mux4_rr_arbiter #(
   parameter int W         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     req,
   input  logic [3:0]     last,
   input  logic [4*W-1:0] in,
   output logic [3:0]     ack,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   input  logic           out_ready,
   output logic [1:0]     sel,
   output logic           busy
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Unpacked view of the requester data so the mux indexes by lane.
   logic [W-1:0]  lane [4];

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign lane[i] = in[i*W +: W];
   end

   // Arbitration search results and per-cycle handshake terms.
   logic          found;
   logic [1:0]    pick;
   logic [1:0]    cand;
   logic          burst_end;
   logic          beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Round-robin search: first requester at or after ptr, wrapping mod 4.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      ack       = 4'b0000;
      out_valid = 1'b0;
      out_last  = 1'b0;
      beat      = 1'b0;
      burst_end = (cnt_q == CW'(MAX_BURST - 1));

      // The select is registered, so the data path never depends on req.
      out_data  = lane[sel_q];

      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               cnt_d   = '0;
               state_d = XFER;
            end
         end

         XFER: begin
            out_valid  = req[sel_q];
            out_last   = out_valid & (last[sel_q] | burst_end);
            beat       = out_valid & out_ready;
            ack[sel_q] = beat;

            if (!out_valid) begin
               // Requester withdrew: release the grant without a final beat.
               ptr_d   = sel_q + 2'd1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (beat) begin
               if (out_last) begin
                  ptr_d   = sel_q + 2'd1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sel  = sel_q;
   assign busy = (state_q == XFER);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter

module tb_mux4_rr_arbiter;

   localparam int W         = 8;
   localparam int MAX_BURST = 4;

   logic           clk;
   logic           rst_n;
   logic [3:0]     req;
   logic [3:0]     last;
   logic [4*W-1:0] in_data;
   logic [3:0]     ack;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic           out_ready;
   logic [1:0]     sel;
   logic           busy;

   int total;
   int bad;

   mux4_rr_arbiter #(
      .W         (W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .in        (in_data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      req       = 4'b0000;
      last      = 4'b0000;
      out_ready = 1'b1;
      in_data   = 32'hD4C3B2A1;

      // Reset state
      #2;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ack",   32'(ack),       32'h0);
      check("rst_last",  32'(out_last),  32'h0);
      check("rst_busy",  32'(busy),      32'h0);
      check("rst_sel",   32'(sel),       32'h0);
      check("rst_data",  32'(out_data),  32'hA1);
      #10;
      rst_n = 1'b1;

      // Single requester, three beats with last on the third
      tick();
      req = 4'b0001;
      in_data[0 +: W] = 8'hA1;
      #1;
      check("s_idle_busy",  32'(busy),      32'h0);
      check("s_idle_valid", 32'(out_valid), 32'h0);
      tick();
      check("s1_busy", 32'(busy),      32'h1);
      check("s1_sel",  32'(sel),       32'h0);
      check("s1_val",  32'(out_valid), 32'h1);
      check("s1_data", 32'(out_data),  32'hA1);
      check("s1_ack",  32'(ack),       32'h1);
      check("s1_last", 32'(out_last),  32'h0);
      tick();
      in_data[0 +: W] = 8'hA2;
      #1;
      check("s2_data", 32'(out_data), 32'hA2);
      check("s2_ack",  32'(ack),      32'h1);
      check("s2_last", 32'(out_last), 32'h0);
      tick();
      in_data[0 +: W] = 8'hA3;
      last = 4'b0001;
      #1;
      check("s3_data", 32'(out_data), 32'hA3);
      check("s3_ack",  32'(ack),      32'h1);
      check("s3_last", 32'(out_last), 32'h1);
      tick();
      // Now idle with ptr=1; full contention starts here, so first grant is 1
      last    = 4'b0000;
      req     = 4'b1111;
      in_data = 32'h44332211;
      #1;
      check("s_end_busy", 32'(busy),      32'h0);
      check("s_end_val",  32'(out_valid), 32'h0);
      check("s_end_sel",  32'(sel),       32'h0);

      // Full contention: grants 1,2,3,0,1, each MAX_BURST beats with a bubble
      for (int g = 0; g < 5; g++) begin
         s = (1 + g) % 4;
         if (g > 0) begin
            check("c_bubble_busy",  32'(busy),      32'h0);
            check("c_bubble_valid", 32'(out_valid), 32'h0);
            check("c_bubble_ack",   32'(ack),       32'h0);
         end
         tick();
         for (int b = 0; b < MAX_BURST; b++) begin
            check("c_sel",  32'(sel),       32'(s));
            check("c_busy", 32'(busy),      32'h1);
            check("c_ack",  32'(ack),       32'(1 << s));
            check("c_data", 32'(out_data),  32'(8'h11 * (s + 1)));
            check("c_last", 32'(out_last),  (b == MAX_BURST - 1) ? 32'h1 : 32'h0);
            tick();
         end
      end

      // Backpressure on requester 1 (ptr=2, only requester 1 asks)
      req = 4'b0010;
      in_data[1*W +: W] = 8'h51;
      #1;
      check("b_idle_busy", 32'(busy), 32'h0);
      tick();
      check("b1_sel",  32'(sel),      32'h1);
      check("b1_ack",  32'(ack),      32'h2);
      check("b1_data", 32'(out_data), 32'h51);
      check("b1_last", 32'(out_last), 32'h0);
      tick();
      in_data[1*W +: W] = 8'h52;
      out_ready = 1'b0;
      #1;
      check("b2_ack",   32'(ack),       32'h0);
      check("b2_valid", 32'(out_valid), 32'h1);
      check("b2_data",  32'(out_data),  32'h52);
      check("b2_last",  32'(out_last),  32'h0);
      tick();
      out_ready = 1'b1;
      #1;
      check("b3_ack",  32'(ack),      32'h2);
      check("b3_data", 32'(out_data), 32'h52);
      check("b3_last", 32'(out_last), 32'h0);
      tick();
      in_data[1*W +: W] = 8'h53;
      out_ready = 1'b0;
      #1;
      check("b4_ack",  32'(ack),      32'h0);
      check("b4_last", 32'(out_last), 32'h0);
      check("b4_data", 32'(out_data), 32'h53);
      tick();
      last = 4'b0010;
      out_ready = 1'b1;
      #1;
      check("b5_ack",  32'(ack),      32'h2);
      check("b5_last", 32'(out_last), 32'h1);
      tick();
      req  = 4'b0000;
      last = 4'b0000;
      #1;
      check("b_end_busy", 32'(busy), 32'h0);

      // Withdraw: requester 2 drops req after two beats
      req = 4'b0100;
      in_data[2*W +: W] = 8'h61;
      #1;
      tick();
      check("w1_sel",  32'(sel),      32'h2);
      check("w1_ack",  32'(ack),      32'h4);
      check("w1_data", 32'(out_data), 32'h61);
      tick();
      check("w2_ack", 32'(ack), 32'h4);
      tick();
      req = 4'b0000;
      #1;
      check("w3_valid", 32'(out_valid), 32'h0);
      check("w3_ack",   32'(ack),       32'h0);
      check("w3_last",  32'(out_last),  32'h0);
      check("w3_busy",  32'(busy),      32'h1);
      tick();

      // Wrap: ptr=3, req=1001 -> grant 3 then 0
      req  = 4'b1001;
      last = 4'b1001;
      #1;
      check("r_idle_busy", 32'(busy), 32'h0);
      tick();
      check("r1_sel",  32'(sel),      32'h3);
      check("r1_ack",  32'(ack),      32'h8);
      check("r1_last", 32'(out_last), 32'h1);
      check("r1_data", 32'(out_data), 32'h44);
      tick();
      check("r_bubble_busy", 32'(busy), 32'h0);
      check("r_bubble_sel",  32'(sel),  32'h3);
      tick();
      check("r2_sel",  32'(sel),      32'h0);
      check("r2_ack",  32'(ack),      32'h1);
      check("r2_last", 32'(out_last), 32'h1);
      tick();
      req  = 4'b0000;
      last = 4'b0000;
      #1;

      // Async reset mid-burst (ptr=1 before reset, only requester 0 asks)
      req = 4'b0001;
      in_data[0 +: W] = 8'h71;
      #1;
      tick();
      check("a1_sel", 32'(sel), 32'h0);
      check("a1_ack", 32'(ack), 32'h1);
      tick();
      check("a2_valid", 32'(out_valid), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("a_rst_valid", 32'(out_valid), 32'h0);
      check("a_rst_ack",   32'(ack),       32'h0);
      check("a_rst_busy",  32'(busy),      32'h0);
      check("a_rst_last",  32'(out_last),  32'h0);
      tick();
      req   = 4'b1111;
      rst_n = 1'b1;
      #1;
      check("a_rel_busy", 32'(busy), 32'h0);
      tick();
      check("a_first_sel",  32'(sel),  32'h0);
      check("a_first_ack",  32'(ack),  32'h1);
      check("a_first_busy", 32'(busy), 32'h1);
      req = 4'b0000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
